// File: rtl/rgmii_pkg.sv
// Shared constants and types for the RGMII receive front end.
package rgmii_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         IDDR_W        = 5;

    typedef enum logic [1:0] {
        SPD_10   = 2'b00,
        SPD_100  = 2'b01,
        SPD_1000 = 2'b10
    } speed_t;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

endpackage

// File: rtl/rgmii_rx_if.sv
// Receive byte stream toward the MAC plus frame status and in-band link status.
interface rgmii_rx_if;
    import rgmii_pkg::*;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_first;
    logic       m_last;
    logic       m_err;
    logic       stat_ok;
    logic       stat_drop;
    logic       link_up;
    speed_t     link_speed;
    logic       full_duplex;

    modport master (
        output m_data, m_valid, m_first, m_last, m_err,
        output stat_ok, stat_drop, link_up, link_speed, full_duplex
    );

    modport slave (
        input m_data, m_valid, m_first, m_last, m_err,
        input stat_ok, stat_drop, link_up, link_speed, full_duplex
    );

endinterface

// File: rtl/rgmii_rx_iddr.sv
// DDR input capture: both edges of one clk cycle are presented together on the next rising edge.
module rgmii_rx_iddr #(
    parameter int INPUT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic [INPUT_WIDTH-1:0] d_i,
    output logic [INPUT_WIDTH-1:0] rise_o,
    output logic [INPUT_WIDTH-1:0] fall_o
);

    logic [INPUT_WIDTH-1:0] rise_q;
    logic [INPUT_WIDTH-1:0] fall_q;

`ifdef SYNTHESIS
    logic [INPUT_WIDTH-1:0] q0;
    logic [INPUT_WIDTH-1:0] q1;

    for (genvar i = 0; i < INPUT_WIDTH; i++) begin : g_bit
        IDDRX1F u_iddr (.D(d_i[i]), .SCLK(clk), .RST(1'b0), .Q0(q0[i]), .Q1(q1[i]));
    end

    always_ff @(posedge clk) begin
        rise_q <= q0;
        fall_q <= q1;
    end
`else
    logic [INPUT_WIDTH-1:0] rise_cap_q;
    logic [INPUT_WIDTH-1:0] fall_cap_q;

    always_ff @(posedge clk) rise_cap_q <= d_i;
    always_ff @(negedge clk) fall_cap_q <= d_i;

    // Re-register so the pair from one cycle lands together in the rising-edge domain.
    always_ff @(posedge clk) begin
        rise_q <= rise_cap_q;
        fall_q <= fall_cap_q;
    end
`endif

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/rgmii_rx.sv
// RGMII 1000 Mb/s receive parser: rebuilds bytes, strips preamble/SFD, marks first/last/error,
// and decodes in-band link status during idle.
module rgmii_rx
    import rgmii_pkg::*;
#(
    parameter int MIN_PREAMBLE = 2,
    parameter int MAX_PREAMBLE = 15,
    parameter bit STATUS_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rxd,
    input  logic             rx_ctl,
    rgmii_rx_if.master       rx_o
);

    localparam int CNT_W = $clog2(MAX_PREAMBLE + 2);

    logic [IDDR_W-1:0] pair_rise;
    logic [IDDR_W-1:0] pair_fall;
    logic              dv;
    logic              er;
    logic [7:0]        rx_byte;
    logic              status_upd;

    rx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       hold_first_q, hold_first_d;
    logic       err_q, err_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic       merr_q, merr_d;
    logic       ok_q, ok_d;
    logic       drop_q, drop_d;
    logic       link_up_q, link_up_d;
    speed_t     speed_q, speed_d;
    logic       duplex_q, duplex_d;

    rgmii_rx_iddr #(.INPUT_WIDTH(IDDR_W)) u_iddr (
        .clk    (clk),
        .d_i    ({rx_ctl, rxd}),
        .rise_o (pair_rise),
        .fall_o (pair_fall)
    );

    assign dv      = pair_rise[4];
    assign er      = pair_rise[4] ^ pair_fall[4];
    assign rx_byte = {pair_fall[3:0], pair_rise[3:0]};

    // Status symbols are only trusted between frames, with a clean idle and a repeated nibble.
    assign status_upd = STATUS_EN && (state_q == WAIT_IDLE || state_q == IDLE) &&
                        !dv && !er && (pair_rise[3:0] == pair_fall[3:0]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        hold_first_d = hold_first_q;
        err_d        = err_q;
        data_d       = 8'h00;
        valid_d      = 1'b0;
        first_d      = 1'b0;
        last_d       = 1'b0;
        merr_d       = 1'b0;
        ok_d         = 1'b0;
        drop_d       = 1'b0;
        link_up_d    = link_up_q;
        speed_d      = speed_q;
        duplex_d     = duplex_q;

        if (status_upd) begin
            link_up_d = rx_byte[0];
            duplex_d  = rx_byte[3];
            if (rx_byte[2:1] != 2'b11) speed_d = speed_t'(rx_byte[2:1]);
        end

        case (state_q)
            WAIT_IDLE: if (!dv) state_d = IDLE;
            IDLE: begin
                if (dv) begin
                    if (rx_byte == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end else if (rx_byte == PREAMBLE_BYTE) begin
                    if (cnt_q >= CNT_W'(MAX_PREAMBLE)) state_d = DROP;
                    else                               cnt_d   = cnt_q + CNT_W'(1);
                end else if (rx_byte == SFD_BYTE && cnt_q >= CNT_W'(MIN_PREAMBLE)) begin
                    state_d    = DATA;
                    hold_vld_d = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                // The held byte is released one pair late so its m_last can be decided.
                if (dv) begin
                    if (hold_vld_q) begin
                        valid_d = 1'b1;
                        data_d  = hold_q;
                        first_d = hold_first_q;
                    end
                    hold_d       = rx_byte;
                    hold_vld_d   = 1'b1;
                    hold_first_d = !hold_vld_q;
                    err_d        = err_q | er;
                end else begin
                    if (hold_vld_q) begin
                        valid_d = 1'b1;
                        data_d  = hold_q;
                        first_d = hold_first_q;
                        last_d  = 1'b1;
                        merr_d  = err_q;
                        ok_d    = !err_q;
                    end else begin
                        drop_d = 1'b1;
                    end
                    hold_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (!dv) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            cnt_q        <= '0;
            hold_q       <= 8'h00;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            merr_q       <= 1'b0;
            ok_q         <= 1'b0;
            drop_q       <= 1'b0;
            link_up_q    <= 1'b0;
            speed_q      <= SPD_10;
            duplex_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            err_q        <= err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            merr_q       <= merr_d;
            ok_q         <= ok_d;
            drop_q       <= drop_d;
            link_up_q    <= link_up_d;
            speed_q      <= speed_d;
            duplex_q     <= duplex_d;
        end
    end

    assign rx_o.m_data      = data_q;
    assign rx_o.m_valid     = valid_q;
    assign rx_o.m_first     = first_q;
    assign rx_o.m_last      = last_q;
    assign rx_o.m_err       = merr_q;
    assign rx_o.stat_ok     = ok_q;
    assign rx_o.stat_drop   = drop_q;
    assign rx_o.link_up     = link_up_q;
    assign rx_o.link_speed  = speed_q;
    assign rx_o.full_duplex = duplex_q;

endmodule

// File: tb/tb_rgmii_rx.sv
// Bench for rgmii_rx: directed frame table, randomized frames against a frame-level model,
// mid-frame reset and in-band status sequences.
module tb_rgmii_rx;
    import rgmii_pkg::*;

    localparam int MIN_P = 2;
    localparam int MAX_P = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rxd;
    logic       rx_ctl;

    rgmii_rx_if rx_if ();

    rgmii_rx #(.MIN_PREAMBLE(MIN_P), .MAX_PREAMBLE(MAX_P), .STATUS_EN(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .rx_ctl (rx_ctl),
        .rx_o   (rx_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic       e;
    } obs_t;

    typedef struct {
        string      name;
        int         n_pre;
        logic [7:0] sfd;
        int         len;
        logic [7:0] pay0;
        int         er_pos;
        int         exp_n;
        bit         exp_ok;
        bit         exp_drop;
        bit         exp_err;
        bit         lat;
    } vec_t;

    obs_t       obs_q[$];
    logic [7:0] pay_q[$];
    int         ok_cnt;
    int         drop_cnt;
    longint     first_t;
    longint     sample_t;
    int         checks = 0;
    int         errors = 0;

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        obs_t o;
        #1;
        if (rx_if.m_valid) begin
            o.d = rx_if.m_data;
            o.f = rx_if.m_first;
            o.l = rx_if.m_last;
            o.e = rx_if.m_err;
            obs_q.push_back(o);
            if (rx_if.m_first && first_t < 0) first_t = $time - 1;
        end
        if (rx_if.stat_ok)   ok_cnt++;
        if (rx_if.stat_drop) drop_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Rise half is set up before the rising edge, fall half before the following falling edge.
    task automatic send_pair(input bit dv, input bit er, input logic [7:0] b);
        @(negedge clk);
        #2;
        rxd    = b[3:0];
        rx_ctl = dv;
        @(posedge clk);
        sample_t = $time;
        #2;
        rxd    = b[7:4];
        rx_ctl = dv ^ er;
    endtask

    task automatic send_idle(input int n, input logic [7:0] b, input bit er);
        for (int i = 0; i < n; i++) send_pair(1'b0, er, b);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        ok_cnt   = 0;
        drop_cnt = 0;
        first_t  = -1;
    endtask

    task automatic run_frame(input string name, input int n_pre, input logic [7:0] sfd,
                             input int er_pos, input int exp_n, input bit exp_ok,
                             input bit exp_drop, input bit exp_err, input bit chk_lat);
        longint t_s;
        int     n;
        clear_obs();
        t_s = -1;
        for (int i = 0; i < n_pre; i++) send_pair(1'b1, 1'b0, PREAMBLE_BYTE);
        send_pair(1'b1, 1'b0, sfd);
        for (int i = 0; i < pay_q.size(); i++) begin
            send_pair(1'b1, (i == er_pos), pay_q[i]);
            if (i == 0) t_s = sample_t;
        end
        send_idle(8, 8'h00, 1'b0);
        chk({name, " count"}, obs_q.size(), exp_n);
        n = (obs_q.size() < exp_n) ? obs_q.size() : exp_n;
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", name, i),
                {obs_q[i].d, obs_q[i].f, obs_q[i].l, obs_q[i].e},
                {pay_q[i], (i == 0), (i == exp_n - 1), (i == exp_n - 1) && exp_err});
        chk({name, " stat_ok"},   ok_cnt,   exp_ok);
        chk({name, " stat_drop"}, drop_cnt, exp_drop);
        if (chk_lat) chk({name, " latency"}, first_t - t_s, 30);
    endtask

    vec_t vecs[11];

    initial begin
        int         n_pre, len, er_pos, exp_n;
        logic [7:0] sfd;
        bit         reach, exp_ok, exp_drop, exp_err;

        vecs[0]  = '{"basic",   7,  8'hD5, 64, 8'h01, -1, 64, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"er10",    7,  8'hD5, 64, 8'h01,  9, 64, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{"pre1",    1,  8'hD5,  8, 8'h01, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"pre16",   16, 8'hD5,  8, 8'h01, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"pre15",   15, 8'hD5,  4, 8'h10, -1,  4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"pre2",    2,  8'hD5,  3, 8'h20, -1,  3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"empty",   7,  8'hD5,  0, 8'h00, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"badsfd",  7,  8'hA5,  5, 8'h01, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"nopre",   0,  8'hD5,  3, 8'h01, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"one",     7,  8'hD5,  1, 8'hA5, -1,  1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"erlast",  7,  8'hD5,  5, 8'h30,  4,  5, 1'b0, 1'b0, 1'b1, 1'b0};

        rst    = 1'b1;
        rxd    = 4'h0;
        rx_ctl = 1'b0;
        clear_obs();
        repeat (4) @(posedge clk);
        #1;
        chk("reset outputs",
            {rx_if.m_valid, rx_if.m_data, rx_if.m_first, rx_if.m_last, rx_if.m_err,
             rx_if.stat_ok, rx_if.stat_drop, rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, 0);
        rst = 1'b0;
        send_idle(4, 8'h00, 1'b0);

        foreach (vecs[v]) begin
            pay_q.delete();
            for (int i = 0; i < vecs[v].len; i++) pay_q.push_back(vecs[v].pay0 + 8'(i));
            run_frame(vecs[v].name, vecs[v].n_pre, vecs[v].sfd, vecs[v].er_pos, vecs[v].exp_n,
                      vecs[v].exp_ok, vecs[v].exp_drop, vecs[v].exp_err, vecs[v].lat);
        end

        // Frame-level model: a frame reaches the data phase only with a legal preamble count
        // and a real SFD; a data phase with no bytes counts as a drop.
        for (int k = 0; k < 25; k++) begin
            n_pre  = $urandom_range(0, 17);
            sfd    = ($urandom_range(0, 9) < 8) ? SFD_BYTE : 8'h5A;
            len    = $urandom_range(0, 12);
            er_pos = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
            reach = (n_pre >= MIN_P) && (n_pre <= MAX_P) && (sfd == SFD_BYTE);
            if (!reach || len == 0) begin
                exp_n = 0; exp_ok = 1'b0; exp_drop = 1'b1; exp_err = 1'b0;
            end else begin
                exp_n = len; exp_err = (er_pos >= 0); exp_ok = !exp_err; exp_drop = 1'b0;
            end
            run_frame($sformatf("rnd%0d", k), n_pre, sfd, er_pos, exp_n, exp_ok, exp_drop,
                      exp_err, 1'b0);
        end

        clear_obs();
        send_idle(4, 8'hDD, 1'b0);
        chk("status DD", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b1, 2'b10, 1'b1});
        send_idle(4, 8'hD3, 1'b0);
        chk("status mismatch", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b1, 2'b10, 1'b1});
        send_idle(4, 8'hFF, 1'b0);
        chk("status speed11", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b1, 2'b10, 1'b1});
        send_idle(4, 8'h22, 1'b0);
        chk("status 22", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b0, 2'b01, 1'b0});
        send_idle(4, 8'hDD, 1'b1);
        chk("status er ignored", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b0, 2'b01, 1'b0});
        chk("false carrier stats", {ok_cnt[7:0], drop_cnt[7:0], 8'(obs_q.size())}, 0);
        send_idle(4, 8'hDD, 1'b0);

        for (int i = 0; i < 7; i++) send_pair(1'b1, 1'b0, PREAMBLE_BYTE);
        send_pair(1'b1, 1'b0, SFD_BYTE);
        for (int i = 0; i < 10; i++) send_pair(1'b1, 1'b0, 8'h80 + 8'(i));
        chk("status held in frame", {rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, {1'b1, 2'b10, 1'b1});
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid outputs",
            {rx_if.m_valid, rx_if.m_data, rx_if.m_first, rx_if.m_last, rx_if.m_err,
             rx_if.stat_ok, rx_if.stat_drop, rx_if.link_up, rx_if.link_speed, rx_if.full_duplex}, 0);
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 5; i++) send_pair(1'b1, 1'b0, 8'h90 + 8'(i));
        send_idle(8, 8'h00, 1'b0);
        chk("rst_mid no valid", obs_q.size(), 0);
        chk("rst_mid no stat", {ok_cnt[7:0], drop_cnt[7:0]}, 0);

        pay_q.delete();
        for (int i = 0; i < 64; i++) pay_q.push_back(8'h01 + 8'(i));
        run_frame("after_rst", 7, SFD_BYTE, -1, 64, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
